// File: rtl/cmpgt_bist_ctrl.sv
// -----------------------------------------------------------------------------
// cmpgt_bist_ctrl
//
// Built-in self-test controller for a WIDTH-bit greater-than comparator.
// On start it walks the comparator through every {a, b} operand pair.
// Each response is folded into a MISR signature, and the number of '1'
// responses is counted. When the run ends, the signature is compared
// against a supplied golden value.
//
// Parameters
//   WIDTH     operand width; the pattern space is 2^(2*WIDTH)
//   SIG_W     MISR width
//   POLY      MISR feedback taps
//   RESP_LAT  comparator response latency in cycles (0..3)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   begin a run (honoured in IDLE or DONE only)
//   golden     in   expected signature, sampled on entry to DONE
//   o          in   comparator response
//   a, b       out  operands to the comparator ({a, b} = pattern counter)
//   busy       out  high while patterns are applied or responses drain
//   done       out  high once the run has completed
//   pass       out  signature matched golden (valid while done)
//   signature  out  current MISR contents
//   ones_cnt   out  number of captured responses equal to 1
// -----------------------------------------------------------------------------
module cmpgt_bist_ctrl #(
  parameter int                 WIDTH    = 4,
  parameter int                 SIG_W    = 16,
  parameter logic [SIG_W-1:0]   POLY     = 16'h1021,
  parameter int                 RESP_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SIG_W-1:0]     golden,
  input  logic                 o,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_W-1:0]     signature,
  output logic [2*WIDTH:0]     ones_cnt
);

  localparam int CNT_W  = 2 * WIDTH;
  localparam int ONES_W = CNT_W + 1;

  // Index of the final FLUSH cycle; only meaningful when RESP_LAT > 0.
  localparam int         FL_LAST_I = (RESP_LAT > 0) ? (RESP_LAT - 1) : 0;
  localparam logic [1:0] FL_LAST   = FL_LAST_I[1:0];

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ONES_W-1:0] ONES_ONE = {{(ONES_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          flush_q;
  logic [SIG_W-1:0]    sig_q;
  logic [SIG_W-1:0]    sig_d;
  logic [ONES_W-1:0]   ones_q;
  logic [ONES_W-1:0]   ones_d;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic                run_s;
  logic                cap_s;
  logic                last_s;

  // One MISR shift: shift left, fold in POLY on carry-out, XOR in the response bit.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic             d);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, d};
  endfunction

  assign run_s  = (state_q == S_RUN);
  assign last_s = &cnt_q;

  // A response is captured when the RUN flag, delayed by RESP_LAT cycles, is
  // high. This lines each capture up with the response to the pattern that
  // was driven RESP_LAT cycles earlier.
  generate
    if (RESP_LAT == 0) begin : g_lat0
      // A combinational comparator answers in the same cycle as the pattern.
      assign cap_s = run_s;
    end else begin : g_pipe
      logic [RESP_LAT-1:0] vld_q;
      logic [RESP_LAT-1:0] vld_d;

      // Shift the RUN flag into the valid pipe.
      always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = run_s;
      end

      // Valid pipe register; reset clears any in-flight captures.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= {RESP_LAT{1'b0}};
        end else begin
          vld_q <= vld_d;
        end
      end

      assign cap_s = vld_q[RESP_LAT-1];
    end
  endgenerate

  // Next signature and ones count for the current cycle's capture.
  always_comb begin
    sig_d  = sig_q;
    ones_d = ones_q;
    if (cap_s) begin
      sig_d = misr_step(sig_q, o);
      if (o) begin
        ones_d = ones_q + ONES_ONE;
      end else begin
        ones_d = ones_q;
      end
    end else begin
      sig_d  = sig_q;
      ones_d = ones_q;
    end
  end

  // Controller FSM with its pattern counter, compaction registers and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      flush_q <= 2'd0;
      sig_q   <= {SIG_W{1'b0}};
      ones_q  <= {ONES_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= {CNT_W{1'b0}};
            flush_q <= 2'd0;
            sig_q   <= {SIG_W{1'b0}};
            ones_q  <= {ONES_W{1'b0}};
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            // Results hold until the next start.
            state_q <= state_q;
          end
        end

        S_RUN: begin
          sig_q  <= sig_d;
          ones_q <= ones_d;
          if (last_s) begin
            // The counter stays at the last pattern so that the operands
            // remain stable while late responses drain.
            if (RESP_LAT == 0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == golden);
            end else begin
              state_q <= S_FLUSH;
              flush_q <= 2'd0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_FLUSH: begin
          sig_q  <= sig_d;
          ones_q <= ones_d;
          if (flush_q == FL_LAST) begin
            // The final capture lands on this same edge, so compare the
            // next-state signature.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (sig_d == golden);
          end else begin
            flush_q <= flush_q + 2'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a         = cnt_q[CNT_W-1:WIDTH];
  assign b         = cnt_q[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_cmpgt_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmpgt_bist_ctrl
//
// Directed bench for cmpgt_bist_ctrl. It uses two instances:
//   u_dut0  RESP_LAT=0, driven by a combinational comparator with selectable
//           faults (none, stuck-at-0, stuck-at-1, single flip at 0x53)
//   u_dut1  RESP_LAT=2, driven by a two-register delayed comparator
// Expected signatures come from a behavioural MISR model in the bench.
// -----------------------------------------------------------------------------
module tb_cmpgt_bist_ctrl;

  logic        clk;
  logic        rst;
  logic        start0;
  logic        start1;
  logic [15:0] golden;
  logic        o0;
  logic        o1;
  logic [3:0]  a0;
  logic [3:0]  b0;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        busy0;
  logic        busy1;
  logic        done0;
  logic        done1;
  logic        pass0;
  logic        pass1;
  logic [15:0] sig0;
  logic [15:0] sig1;
  logic [8:0]  ones0;
  logic [8:0]  ones1;

  logic [1:0]  mode;
  int          sel;
  logic        cmp0;
  logic        d1_q;
  logic        d2_q;
  logic        cur_busy;
  logic [7:0]  cur_ab;

  int          n_asserts;
  int          n_fail;
  int          cycles;
  bit          pat_ok;
  logic [15:0] good_sig;
  logic [15:0] s1_sig;
  logic [15:0] flip_sig;

  cmpgt_bist_ctrl #(.WIDTH(4), .SIG_W(16), .POLY(16'h1021), .RESP_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .golden(golden), .o(o0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .signature(sig0), .ones_cnt(ones0)
  );

  cmpgt_bist_ctrl #(.WIDTH(4), .SIG_W(16), .POLY(16'h1021), .RESP_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .golden(golden), .o(o1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .ones_cnt(ones1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator for u_dut0, with fault injection selected by mode.
  assign cmp0 = (a0 > b0);
  assign o0   = (mode == 2'd0) ? cmp0 :
                (mode == 2'd1) ? 1'b0 :
                (mode == 2'd2) ? 1'b1 :
                (cmp0 ^ ({a0, b0} == 8'h53));

  // Comparator for u_dut1, with a two-cycle response latency.
  always @(posedge clk) begin
    d1_q <= (a1 > b1);
    d2_q <= d1_q;
  end
  assign o1 = d2_q;

  assign cur_busy = (sel == 0) ? busy0 : busy1;
  assign cur_ab   = (sel == 0) ? {a0, b0} : {a1, b1};

  function automatic logic [15:0] misr(input logic [15:0] s, input logic d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    n[0] = n[0] ^ d;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  // Optionally pulse start, then count busy cycles (bounded) while checking
  // the pattern order on a/b. Optionally pulse start at busy cycles 10 and 100.
  task automatic run(input bit do_start, input bit pulse_mid);
    logic [7:0] exp_ab;
    if (do_start) begin
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
    end
    cycles = 0;
    pat_ok = 1'b1;
    while (cur_busy && cycles < 400) begin
      exp_ab = (cycles > 255) ? 8'hFF : cycles[7:0];
      if (cur_ab !== exp_ab) pat_ok = 1'b0;
      cycles++;
      set_start(pulse_mid && (cycles == 10 || cycles == 100));
      @(negedge clk);
    end
    set_start(1'b0);
  endtask

  initial begin
    logic [15:0] s;
    n_asserts = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start0    = 1'b0;
    start1    = 1'b0;
    mode      = 2'd0;
    sel       = 0;

    // Reference signatures.
    s = 16'h0000;
    for (int k = 0; k < 256; k++) s = misr(s, (k[7:4] > k[3:0]));
    good_sig = s;
    s = 16'h0000;
    for (int k = 0; k < 256; k++) s = misr(s, 1'b1);
    s1_sig = s;
    s = 16'h0000;
    for (int k = 0; k < 256; k++) s = misr(s, (k[7:4] > k[3:0]) ^ (k == 8'h53));
    flip_sig = s;
    golden = good_sig;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ab",   {a0, b0}, 8'h00);
    chk("rst_busy", busy0,    1'b0);
    chk("rst_done", done0,    1'b0);
    chk("rst_pass", pass0,    1'b0);
    chk("rst_sig",  sig0,     16'h0000);
    chk("rst_ones", ones0,    9'd0);
    rst = 1'b0;

    // Reset applied mid-run at cycle 40.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_busy_pre", busy0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ab",   {a0, b0}, 8'h00);
    chk("midrst_busy", busy0,    1'b0);
    chk("midrst_done", done0,    1'b0);
    chk("midrst_sig",  sig0,     16'h0000);
    chk("midrst_ones", ones0,    9'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fault-free run, RESP_LAT=0.
    run(1'b1, 1'b0);
    chk("good_cycles", cycles, 32'd256);
    chk("good_order",  pat_ok, 1'b1);
    chk("good_done",   done0,  1'b1);
    chk("good_pass",   pass0,  1'b1);
    chk("good_ones",   ones0,  9'd120);
    chk("good_sig",    sig0,   good_sig);
    chk("good_ab_end", {a0, b0}, 8'hFF);

    // Restart from DONE clears the results; start pulses mid-run are ignored.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("restart_busy", busy0, 1'b1);
    chk("restart_done", done0, 1'b0);
    chk("restart_pass", pass0, 1'b0);
    chk("restart_sig",  sig0,  16'h0000);
    chk("restart_ones", ones0, 9'd0);
    run(1'b0, 1'b1);
    chk("ign_cycles", cycles, 32'd256);
    chk("ign_order",  pat_ok, 1'b1);
    chk("ign_pass",   pass0,  1'b1);
    chk("ign_ones",   ones0,  9'd120);

    // Stuck-at-0 on the response.
    mode = 2'd1;
    run(1'b1, 1'b0);
    chk("sa0_cycles", cycles, 32'd256);
    chk("sa0_ones",   ones0,  9'd0);
    chk("sa0_sig",    sig0,   16'h0000);
    chk("sa0_pass",   pass0,  1'b0);

    // Stuck-at-1 on the response.
    mode = 2'd2;
    run(1'b1, 1'b0);
    chk("sa1_ones", ones0, 9'd256);
    chk("sa1_sig",  sig0,  s1_sig);
    chk("sa1_pass", pass0, 1'b0);

    // Single response flip at pattern 0x53 (5 > 3 becomes 0).
    mode = 2'd3;
    run(1'b1, 1'b0);
    chk("flip_ones", ones0, 9'd119);
    chk("flip_sig",  sig0,  flip_sig);
    chk("flip_pass", pass0, 1'b0);

    // RESP_LAT=2 with a delayed comparator.
    mode = 2'd0;
    sel  = 1;
    run(1'b1, 1'b0);
    chk("lat2_cycles", cycles, 32'd258);
    chk("lat2_order",  pat_ok, 1'b1);
    chk("lat2_done",   done1,  1'b1);
    chk("lat2_pass",   pass1,  1'b1);
    chk("lat2_ones",   ones1,  9'd120);
    chk("lat2_sig",    sig1,   good_sig);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
